comparador_generico: RTL and testbench

COMPARADOR_GENERICO -- requirements
Module: comparador_generico

---
 rtl/comparador_generico.sv | 133 +++++++++++++
 tb/tb_comparador_generico.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/comparador_generico.sv
// rtl/comparador_generico.sv - two-stage pipelined generic magnitude comparator
// Optional feature macro: COMPARADOR_MAX_EN (MAX output carries the larger operand)
module comparador_generico #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [2:0]   mode_i,
   input  logic         signed_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic         out_o,
   output logic         gt_o,
   output logic         eq_o,
   output logic         lt_o,
   output logic [W-1:0] max_o
);

   // Stage 1 state: the extended difference already carries the signedness,
   // so SIGNED itself is not needed past this point.
   logic         v1_q;
   logic [W:0]   diff_q, diff_d;
   logic         eq1_q, eq1_d;
   logic [2:0]   mode1_q;

   // Stage 2 state (the visible outputs)
   logic         v2_q;
   logic         gt_q, gt_d;
   logic         eq_q;
   logic         lt_q, lt_d;
   logic         out_q, out_d;

   logic         en1, en2;
   logic [W:0]   a_ext, b_ext;

   // Stage 2 may load when empty or draining; stage 1 when empty or stage 2 moves
   assign en2        = !v2_q || out_ready_i;
   assign en1        = !v1_q || en2;
   assign in_ready_o = en1;

   // Extend to W+1 bits so the difference never overflows in either interpretation
   assign a_ext  = {signed_i & a_i[W-1], a_i};
   assign b_ext  = {signed_i & b_i[W-1], b_i};
   assign diff_d = a_ext - b_ext;
   assign eq1_d  = (a_i == b_i);

   // Stage 1 capture of difference, equality bit and relation select
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v1_q    <= 1'b0;
         diff_q  <= '0;
         eq1_q   <= 1'b0;
         mode1_q <= 3'd0;
      end else if (en1) begin
         v1_q <= in_valid_i;
         if (in_valid_i) begin
            diff_q  <= diff_d;
            eq1_q   <= eq1_d;
            mode1_q <= mode_i;
         end
      end
   end

   // Flag decode: negative difference means A<B; nonzero non-negative means A>B
   always_comb begin
      lt_d = diff_q[W];
      gt_d = !diff_q[W] && (|diff_q[W-1:0]);
      case (mode1_q)
         3'd0:    out_d = gt_d;
         3'd1:    out_d = gt_d || eq1_q;
         3'd2:    out_d = lt_d;
         3'd3:    out_d = lt_d || eq1_q;
         3'd4:    out_d = eq1_q;
         3'd5:    out_d = !eq1_q;
         default: out_d = 1'b0;
      endcase
   end

   // Stage 2 result registers; hold while the consumer stalls
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         v2_q  <= 1'b0;
         gt_q  <= 1'b0;
         eq_q  <= 1'b0;
         lt_q  <= 1'b0;
         out_q <= 1'b0;
      end else if (en2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            gt_q  <= gt_d;
            eq_q  <= eq1_q;
            lt_q  <= lt_d;
            out_q <= out_d;
         end
      end
   end

`ifdef COMPARADOR_MAX_EN
   logic [W-1:0] a1_q, b1_q, max_q;

   // Operand copies for MAX travel alongside stage 1 and select into stage 2
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         a1_q  <= '0;
         b1_q  <= '0;
         max_q <= '0;
      end else begin
         if (en1 && in_valid_i) begin
            a1_q <= a_i;
            b1_q <= b_i;
         end
         if (en2 && v1_q) begin
            max_q <= diff_q[W] ? b1_q : a1_q;
         end
      end
   end

   assign max_o = max_q;
`else
   assign max_o = '0;
`endif

   assign out_valid_o = v2_q;
   assign out_o       = out_q;
   assign gt_o        = gt_q;
   assign eq_o        = eq_q;
   assign lt_o        = lt_q;

endmodule

// File: tb/tb_comparador_generico.sv
// tb/tb_comparador_generico.sv - randomized and directed bench for comparador_generico
module tb_comparador_generico;

   typedef struct {
      logic        gt, eq, lt, o;
      logic [31:0] mx;
   } res_t;

   typedef struct {
      res_t r;
      int   acc;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       iv8, ir8, ov8, ordy8, s8, out8, gt8, eq8, lt8;
   logic [7:0] a8, b8, max8;
   logic [2:0] m8;

   logic       iv1, ir1, ov1, s1, out1, gt1, eq1, lt1;
   logic [0:0] a1, b1, max1;
   logic [2:0] m1;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   comparador_generico #(.W(8)) dut8 (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv8), .in_ready_o(ir8),
      .a_i(a8), .b_i(b8), .mode_i(m8), .signed_i(s8),
      .out_valid_o(ov8), .out_ready_i(ordy8), .out_o(out8),
      .gt_o(gt8), .eq_o(eq8), .lt_o(lt8), .max_o(max8)
   );

   comparador_generico #(.W(1)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(iv1), .in_ready_o(ir1),
      .a_i(a1), .b_i(b1), .mode_i(m1), .signed_i(s1),
      .out_valid_o(ov1), .out_ready_i(1'b1), .out_o(out1),
      .gt_o(gt1), .eq_o(eq1), .lt_o(lt1), .max_o(max1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: interpret operands as integers and apply the relation directly
   function automatic res_t model(input int w, input int unsigned a, input int unsigned b,
                                  input int m, input bit s);
      longint va, vb;
      res_t   r;
      va = longint'(a);
      vb = longint'(b);
      if (s && ((a >> (w - 1)) & 1) == 1) va = va - (longint'(1) << w);
      if (s && ((b >> (w - 1)) & 1) == 1) vb = vb - (longint'(1) << w);
      r.gt = (va > vb);
      r.eq = (va == vb);
      r.lt = (va < vb);
      case (m)
         0: r.o = (va > vb);
         1: r.o = (va >= vb);
         2: r.o = (va < vb);
         3: r.o = (va <= vb);
         4: r.o = (va == vb);
         5: r.o = (va != vb);
         default: r.o = 1'b0;
      endcase
`ifdef COMPARADOR_MAX_EN
      r.mx = (va < vb) ? b : a;
`else
      r.mx = 32'd0;
`endif
      return r;
   endfunction

   task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] m, input bit s, input bit ordy);
      iv8 = v; a8 = a; b8 = b; m8 = m; s8 = s; ordy8 = ordy;
   endtask

   // One clock of the W=8 DUT: check handshake and head result, then update the model
   task automatic step();
      bit   exp_rdy, exp_ov, fire_in, fire_out;
      ent_t e;
      @(negedge clk);
      exp_rdy = (q.size() < 2) || ordy8;
      exp_ov  = (q.size() > 0) && !(q.size() == 1 && q[0].acc == cyc);
      check("in_ready", ir8, exp_rdy);
      check("out_valid", ov8, exp_ov);
      if (exp_ov) begin
         check("out", out8, q[0].r.o);
         check("gt", gt8, q[0].r.gt);
         check("eq", eq8, q[0].r.eq);
         check("lt", lt8, q[0].r.lt);
         check("max", {24'd0, max8}, q[0].r.mx);
      end
      fire_out = exp_ov && ordy8;
      fire_in  = iv8 && exp_rdy;
      e.r      = model(8, a8, b8, m8, s8);
      @(posedge clk);
      cyc++;
      e.acc = cyc;
      if (fire_out) void'(q.pop_front());
      if (fire_in) q.push_back(e);
      #1;
   endtask

   initial begin
      res_t r;
      logic [7:0] ra;
      rst_n = 1'b0;
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1);
      iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; m1 = 3'd0; s1 = 1'b0;
      #3;
      check("rst_ov", ov8, 1'b0);
      check("rst_out", {out8, gt8, eq8, lt8}, 4'h0);
      check("rst_max", max8, 8'h00);
      check("rst_in_ready", ir8, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // GT unsigned, two-cycle latency
      drive(1, 8'hC8, 8'h64, 3'd0, 0, 1); step();
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1); step();
      check("r030_ov", ov8, 1'b1);
      check("r030_out", out8, 1'b1);
      check("r030_gt", gt8, 1'b1);
`ifdef COMPARADOR_MAX_EN
      check("r030_max", max8, 8'hC8);
`else
      check("r030_max", max8, 8'h00);
`endif
      step();

      // Extremes: signed 80 < 7F, unsigned 80 > 7F
      drive(1, 8'h80, 8'h7F, 3'd2, 1, 1); step();
      drive(1, 8'h80, 8'h7F, 3'd2, 0, 1); step();
      check("r031s_out", out8, 1'b1);
      check("r031s_lt", lt8, 1'b1);
`ifdef COMPARADOR_MAX_EN
      check("r031s_max", max8, 8'h7F);
`else
      check("r031s_max", max8, 8'h00);
`endif
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1); step();
      check("r031u_out", out8, 1'b0);
      check("r031u_gt", gt8, 1'b1);
      step();

      // Reserved mode with equal operands
      drive(1, 8'h03, 8'h03, 3'd7, 0, 1); step();
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1); step();
      check("r035_out", out8, 1'b0);
      check("r035_eq", eq8, 1'b1);
      step();

      // Six back-to-back equality compares, alternating equal/unequal
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom);
         drive(1, ra, (i % 2 == 0) ? ra : (ra ^ 8'h01), 3'd4, 0, 1);
         step();
      end
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1);
      for (int i = 0; i < 3; i++) step();

      // Consumer stall for 4 cycles in the middle of a stream
      for (int i = 0; i < 10; i++) begin
         drive(1, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), !(i >= 2 && i < 6));
         step();
      end
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1);
      for (int i = 0; i < 3; i++) step();

      // Asynchronous reset with both stages full
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'($urandom), 8'($urandom), 3'd0, 0, 0);
         step();
      end
      #2 rst_n = 1'b0;
      #1;
      check("r034_ov", ov8, 1'b0);
      check("r034_flags", {out8, gt8, eq8, lt8}, 4'h0);
      check("r034_max", max8, 8'h00);
      check("r034_in_ready", ir8, 1'b1);
      q.delete();
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1, 8'h10, 8'h20, 3'd3, 0, 1); step();
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1);
      check("r034_lat1", ov8, 1'b0);
      step();
      check("r034_lat2", ov8, 1'b1);
      check("r034_res", out8, 1'b1);
      step();

      // Randomized traffic with random back-pressure and biased equality
      for (int i = 0; i < 400; i++) begin
         ra = 8'($urandom);
         drive(($urandom_range(0, 9) < 8), ra,
               ($urandom_range(0, 3) == 0) ? ra : 8'($urandom),
               3'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7));
         step();
      end
      drive(0, 8'h00, 8'h00, 3'd0, 0, 1);
      for (int i = 0; i < 4; i++) step();

      // W=1 exhaustive: every operand pair, mode and signedness
      for (int v = 0; v < 64; v++) begin
         a1 = 1'(v & 1); b1 = 1'((v >> 1) & 1); s1 = 1'((v >> 2) & 1); m1 = 3'(v >> 3);
         r = model(1, a1, b1, m1, s1);
         iv1 = 1'b1;
         check("w1_in_ready", ir1, 1'b1);
         @(posedge clk); #1;
         iv1 = 1'b0;
         check("w1_lat", ov1, 1'b0);
         @(posedge clk); #1;
         check("w1_ov", ov1, 1'b1);
         check("w1_out", out1, r.o);
         check("w1_flags", {gt1, eq1, lt1}, {r.gt, r.eq, r.lt});
         check("w1_max", {31'd0, max1}, r.mx);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
